// File: rtl/serial_pkg.sv
// Shared definitions for the 8N1 serial receiver: FSM states and framing constants.
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } rx_state_t;

    // Smallest usable clocks-per-bit; smaller requests are clamped up to this.
    localparam int   DIV_MIN    = 4;
    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/serial_rx_fifo.sv
// Small byte FIFO with valid/ready read side and a drop indication for pushes
// that find it full with no simultaneous pop.
module serial_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       pop,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [7:0]  mem [DEPTH];
    logic        empty;
    logic        full;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign valid   = !empty;
    assign rdata   = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    // Pointer update; both may move in the same cycle.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write.
    // NOTE: the array has no reset; entries are only visible once written, so
    // resetting them would cost logic for no observable effect.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/serial_rx.sv
// 8N1 asynchronous serial receiver: synchroniser, mid-bit sampling FSM,
// receive FIFO and sticky framing/overrun flags.
module serial_rx
    import serial_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic [DIV_W-1:0] divisor,
    input  logic             rx_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             frame_err_o,
    output logic             overrun_o,
    input  logic             clr_i
);

    logic             rx_m;
    logic             rx_s;
    logic             rx_d;
    logic             fell;
    rx_state_t        state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] eff_div;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             sample;
    logic             push;
    logic             frame_set;
    logic             drop;

    assign fell      = rx_d && !rx_s;
    assign eff_div   = (divisor < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : divisor;
    assign sample    = (cnt == '0);
    assign push      = (state == STOP) && sample && (rx_s == STOP_LEVEL);
    assign frame_set = (state == STOP) && sample && (rx_s != STOP_LEVEL);
    assign busy_o    = (state != IDLE);

    // Two-flop synchroniser plus one delayed copy for falling-edge detection.
    // NOTE: every flop here uses <= so each stage takes the previous stage's
    // old value; blocking = would collapse the chain into a single flop.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
            rx_d <= 1'b1;
        end else begin
            rx_m <= rx_i;
            rx_s <= rx_m;
            rx_d <= rx_s;
        end
    end

    // Frame FSM: half-bit wait into the start bit, then one sample per bit time.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            div_q   <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fell) begin
                        div_q <= eff_div;
                        cnt   <= (eff_div >> 1) - DIV_W'(1);
                        state <= START;
                    end
                end
                START: begin
                    if (!sample) begin
                        cnt <= cnt - DIV_W'(1);
                    end else if (!rx_s) begin
                        cnt     <= div_q - DIV_W'(1);
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (!sample) begin
                        cnt <= cnt - DIV_W'(1);
                    end else begin
                        shift <= {rx_s, shift[7:1]};
                        cnt   <= div_q - DIV_W'(1);
                        if (bit_idx == 3'(DATA_BITS - 1)) state   <= STOP;
                        else                              bit_idx <= bit_idx + 3'd1;
                    end
                end
                STOP: begin
                    if (!sample)                  cnt   <= cnt - DIV_W'(1);
                    else if (rx_s == STOP_LEVEL)  state <= IDLE;
                    else                          state <= BRK;
                end
                BRK: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            frame_err_o <= frame_set || (frame_err_o && !clr_i);
            overrun_o   <= drop      || (overrun_o   && !clr_i);
        end
    end

    serial_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_n (rst_n),
        .push  (push),
        .wdata (shift),
        .pop   (ready_i),
        .rdata (data_o),
        .valid (valid_o),
        .drop  (drop)
    );

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: drives 8N1 frames on rx_i and checks received
// bytes, timing, sticky flags, FIFO overflow and reset behaviour.
module tb_serial_rx;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] divisor = 16'd16;
    logic        rx_i = 1'b1;
    logic [7:0]  data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic        frame_err_o;
    logic        overrun_o;
    logic        clr_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [7:0] got_q[$];
    int         got_t[$];

    serial_rx #(
        .DIV_W      (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .divisor     (divisor),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .busy_o      (busy_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .clr_i       (clr_i)
    );

    initial forever #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Record every byte handed over (valid && ready) and the cycle it was seen.
    always begin
        @(negedge clk_i);
        #2;
        if (valid_o && ready_i) begin
            got_q.push_back(data_o);
            got_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] got(input int i);
        return (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD;
    endfunction

    function automatic int got_time(input int i);
        return (i < got_t.size()) ? got_t[i] : -1;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic clear_log();
        got_q.delete();
        got_t.delete();
    endtask

    // Drive one frame starting at the current negedge; stop level is left on the line.
    task automatic send_byte(input logic [7:0] b, input logic stop, input int d, output int t0);
        t0   = cyc;
        rx_i = 1'b0;
        wait_clk(d);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_clk(d);
        end
        rx_i = stop;
        wait_clk(d);
    endtask

    int t_a;
    int t_b;
    int busy_cnt;

    initial begin
        // Reset state
        wait_clk(3);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
        rst_n = 1'b1;
        wait_clk(5);
        check("idle_frame", 32'(frame_err_o), 32'd0);
        check("idle_overrun", 32'(overrun_o), 32'd0);

        // Back-to-back 0x48, 0x65 at 16 clocks/bit; visible 1 clock after stop sample
        clear_log();
        send_byte(8'h48, 1'b1, 16, t_a);
        send_byte(8'h65, 1'b1, 16, t_b);
        wait_clk(10);
        check("b2b_count", 32'(got_q.size()), 32'd2);
        check("b2b_byte0", got(0), 32'h48);
        check("b2b_byte1", got(1), 32'h65);
        check("b2b_lat0", 32'(got_time(0) - t_a), 32'd155);
        check("b2b_lat1", 32'(got_time(1) - t_b), 32'd155);
        check("b2b_frame", 32'(frame_err_o), 32'd0);
        check("b2b_overrun", 32'(overrun_o), 32'd0);

        // Divisor change mid-frame is ignored
        clear_log();
        fork
            send_byte(8'hC3, 1'b1, 16, t_a);
            begin
                wait_clk(40);
                divisor = 16'd40;
            end
        join
        divisor = 16'd16;
        wait_clk(10);
        check("divchg_count", 32'(got_q.size()), 32'd1);
        check("divchg_byte", got(0), 32'hC3);

        // Slow line 0xA5 at 1040 clocks/bit; busy for 9.5 bit times
        clear_log();
        divisor  = 16'd1040;
        busy_cnt = 0;
        fork
            send_byte(8'hA5, 1'b1, 1040, t_a);
            begin
                repeat (11 * 1040) begin
                    @(negedge clk_i);
                    if (busy_o) busy_cnt++;
                end
            end
        join
        check("slow_count", 32'(got_q.size()), 32'd1);
        check("slow_byte", got(0), 32'hA5);
        check("slow_busy", 32'(busy_cnt), 32'd9880);
        divisor = 16'd16;

        // 3-clock glitch: start detected, rejected at mid start bit
        clear_log();
        rx_i = 1'b0;
        wait_clk(3);
        rx_i = 1'b1;
        wait_clk(2);
        check("glitch_busy_on", 32'(busy_o), 32'd1);
        wait_clk(30);
        check("glitch_busy_off", 32'(busy_o), 32'd0);
        check("glitch_count", 32'(got_q.size()), 32'd0);
        check("glitch_frame", 32'(frame_err_o), 32'd0);

        // Framing error with long break, then a good byte
        clear_log();
        send_byte(8'h3C, 1'b0, 16, t_a);
        wait_clk(40 * 16 - 16);
        check("brk_frame", 32'(frame_err_o), 32'd1);
        check("brk_busy", 32'(busy_o), 32'd1);
        rx_i = 1'b1;
        wait_clk(32);
        check("brk_exit", 32'(busy_o), 32'd0);
        send_byte(8'h11, 1'b1, 16, t_a);
        wait_clk(10);
        check("brk_count", 32'(got_q.size()), 32'd1);
        check("brk_byte", got(0), 32'h11);
        check("brk_sticky", 32'(frame_err_o), 32'd1);
        clr_i = 1'b1;
        wait_clk(1);
        clr_i = 1'b0;
        wait_clk(1);
        check("brk_clr", 32'(frame_err_o), 32'd0);

        // Overflow: five bytes into a four-entry FIFO with no reader
        clear_log();
        ready_i = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1, 16, t_a);
        wait_clk(10);
        check("ovf_flag", 32'(overrun_o), 32'd1);
        check("ovf_valid", 32'(valid_o), 32'd1);
        check("ovf_head", 32'(data_o), 32'h01);
        ready_i = 1'b1;
        wait_clk(10);
        check("ovf_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check($sformatf("ovf_drain%0d", i), got(i), 32'(i + 1));
        check("ovf_empty", 32'(valid_o), 32'd0);
        check("ovf_empty_data", 32'(data_o), 32'h00);

        // Reset mid-frame with a byte queued and overrun still set
        clear_log();
        ready_i = 1'b0;
        send_byte(8'h42, 1'b1, 16, t_a);
        wait_clk(5);
        check("pre_rst_valid", 32'(valid_o), 32'd1);
        rx_i = 1'b0;
        wait_clk(16);
        for (int i = 0; i < 3; i++) begin
            rx_i = 1'b1;
            wait_clk(16);
        end
        rx_i = 1'b0;
        wait_clk(8);
        rst_n = 1'b0;
        rx_i  = 1'b1;
        wait_clk(2);
        check("mid_rst_data", 32'(data_o), 32'h00);
        check("mid_rst_valid", 32'(valid_o), 32'd0);
        check("mid_rst_busy", 32'(busy_o), 32'd0);
        check("mid_rst_frame", 32'(frame_err_o), 32'd0);
        check("mid_rst_overrun", 32'(overrun_o), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);
        ready_i = 1'b1;
        send_byte(8'h99, 1'b1, 16, t_a);
        wait_clk(10);
        check("post_rst_count", 32'(got_q.size()), 32'd1);
        check("post_rst_byte", got(0), 32'h99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
